mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 4: beats per read transaction (line refill).
REQ-002 Parameter TIMEOUT, default 255: max cycles waiting for one mem_ack before abort.
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 i_req  in  1  icache refill request; held until i_done.
REQ-006 i_addr  in  32  icache line base address; stable while i_req.
REQ-007 d_req  in  1  dcache request; held until d_done.
REQ-008 d_we  in  1  1 = single-beat write, 0 = BURST_LEN-beat read.
REQ-009 d_addr  in  32  dcache address; stable while d_req.
REQ-010 d_wdata  in  32  dcache write data.
REQ-011 rsp_data  out  32  registered read beat data.
REQ-012 i_valid / d_valid  out  1 each  rsp_data holds a beat for that requester.
REQ-013 i_done / d_done  out  1 each  one-cycle transaction-complete pulse.
REQ-014 bus_err  out  1  qualifies a done pulse; transaction aborted by timeout.
REQ-015 mem_req  out  1  main-memory beat request.
REQ-016 mem_we  out  1  main-memory write enable.
REQ-017 mem_addr  out  32  main-memory beat address.
REQ-018 mem_wdata  out  32  main-memory write data.
REQ-019 mem_ack  in  1  beat accepted/completed; rdata valid same cycle.
REQ-020 mem_rdata  in  32  main-memory read data.

Function
REQ-021 FSM states: IDLE, BUSY_I, BUSY_D, DONE; all outputs registered.
REQ-022 IDLE, no request pending: stay IDLE, mem_req=0.
REQ-023 IDLE, exactly one req: grant it; enter BUSY_I or BUSY_D; mem_req=1 from the next cycle.
REQ-024 IDLE, both req: grant the requester not granted last; after reset, d wins first tie.
REQ-025 Grant latches addr, we, wdata and requester ID; later input changes are ignored until DONE.
REQ-026 BUSY: mem_req held 1, mem_addr/mem_we/mem_wdata stable until mem_ack.
REQ-027 Each mem_ack on a read: rsp_data<=mem_rdata and the owner's valid=1 next cycle (one cycle only); beat counter increments; mem_addr<=mem_addr+4.
REQ-028 Read beat addresses: base, base+4, ..., base+4*(BURST_LEN-1); low 2 address bits forced to 0; carry past bit 31 wraps.
REQ-029 mem_req stays 1 between beats; no bubble cycles.
REQ-030 Final ack (beat BURST_LEN-1 on reads, the first ack on writes): mem_req=0 next cycle; enter DONE.
REQ-031 DONE: owner's done=1 for exactly one cycle, then IDLE; the last read valid and done coincide.
REQ-032 Requester drops req on the edge where done=1; the next grant is evaluated in IDLE, giving a minimum 1 idle cycle between transactions.
REQ-033 Wait counter clears on grant and on each ack, and increments each BUSY cycle without ack.
REQ-034 Timeout: counter reaching TIMEOUT forces mem_req=0 and DONE with bus_err=1 alongside done; remaining beats are not issued.
REQ-035 mem_ack outside BUSY is ignored, with no output change.
REQ-036 Write: no valid pulse; d_done only.

Reset
REQ-037 reset=0 at a posedge: state=IDLE, all outputs 0, counters 0, last-grant=i (d wins the next tie); applies mid-transaction and aborts with no done pulse.
REQ-038 The first grant can occur on the first edge with reset=1.

Structure
REQ-039 The FSM state encoding, requester-ID encoding and default BURST_LEN/TIMEOUT belong in the shared core defines package.
REQ-040 One sub-module, mem_arb_prio: two-requester round-robin picker (req_i, req_d, last -> grant); the FSM and datapath stay in mem_arbiter.

Verification
REQ-041 Single i read at 0x100 with mem_ack every cycle -> mem_addr 0x100,0x104,0x108,0x10C; 4 i_valid pulses; i_done the cycle after the 4th ack.
REQ-042 i_req and d_req both rise in IDLE after reset -> d is served first, then i; the next simultaneous tie goes to d.
REQ-043 d write addr 0x2000, data 0xDEADBEEF, ack delayed 3 cycles -> mem_req/mem_we/mem_addr/mem_wdata stable for 4 cycles; d_done, no d_valid.
REQ-044 TIMEOUT=255 with mem_ack never asserted -> mem_req drops after 255 cycles; done=1 with bus_err=1; back to IDLE.
REQ-045 reset=0 after the 2nd read beat -> all outputs 0 next cycle with no done; a new request after release starts at beat 0.
REQ-046 Read at 0xFFFFFFF8 -> beat addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the two-requester memory arbiter.
// Holds the FSM state encoding, requester IDs, default burst length and
// timeout, counter width and the word-alignment helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_TIMEOUT   = 255;
  localparam int CNT_W         = 16;

  // Beat addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: round-robin picker for the icache/dcache requesters.
// Ports:
//   req_i, req_d  pending requests
//   last          requester granted most recently (req_id_t encoding)
//   grant_valid   at least one request pending
//   grant         chosen requester (req_id_t encoding)
module mem_arb_prio
  import mem_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last,
  output logic grant_valid,
  output logic grant
);

  // Pick a requester; on a tie the one not granted last wins.
  always_comb begin
    grant_valid = req_i | req_d;
    grant       = REQ_I;
    if (req_i && req_d) begin
      grant = (last == REQ_I) ? REQ_D : REQ_I;
    end else if (req_d) begin
      grant = REQ_D;
    end else begin
      grant = REQ_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between an icache refill port
// (BURST_LEN-beat reads) and a dcache port (single-beat writes or
// BURST_LEN-beat reads). All outputs are registered.
// Ports:
//   clock, reset            clock, synchronous active-low reset
//   i_req, i_addr           icache refill request and line base address
//   d_req, d_we, d_addr,
//   d_wdata                 dcache request, write flag, address, write data
//   rsp_data                read beat data; i_valid / d_valid mark its owner
//   i_done, d_done          one-cycle completion pulses; bus_err marks a timeout
//   mem_req, mem_we,
//   mem_addr, mem_wdata     main-memory beat request
//   mem_ack, mem_rdata      beat completion and read data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] rsp_data,
  output logic        i_valid,
  output logic        d_valid,
  output logic        i_done,
  output logic        d_done,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] TMO_CNT   = CNT_W'(TIMEOUT);

  arb_state_t       state_r, state_nxt;
  req_id_t          owner_r, owner_nxt;
  req_id_t          last_r, last_nxt;
  logic [CNT_W-1:0] beat_r, beat_nxt;
  logic [CNT_W-1:0] wait_r, wait_nxt;
  logic             req_nxt, we_nxt;
  logic [31:0]      addr_nxt, wdata_nxt, rsp_nxt;
  logic             i_valid_nxt, d_valid_nxt, i_done_nxt, d_done_nxt, err_nxt;
  logic             finish_s;
  logic             grant_valid_s;
  logic             grant_s;

  mem_arb_prio u_prio (
    .req_i       (i_req),
    .req_d       (d_req),
    .last        (last_r),
    .grant_valid (grant_valid_s),
    .grant       (grant_s)
  );

  // Next-state and next-output logic; pulse outputs default low, the rest hold.
  always_comb begin
    state_nxt   = state_r;
    owner_nxt   = owner_r;
    last_nxt    = last_r;
    beat_nxt    = beat_r;
    wait_nxt    = wait_r;
    req_nxt     = mem_req;
    we_nxt      = mem_we;
    addr_nxt    = mem_addr;
    wdata_nxt   = mem_wdata;
    rsp_nxt     = rsp_data;
    i_valid_nxt = 1'b0;
    d_valid_nxt = 1'b0;
    i_done_nxt  = 1'b0;
    d_done_nxt  = 1'b0;
    err_nxt     = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) begin
          // Latch the whole request so later input changes are ignored.
          owner_nxt = req_id_t'(grant_s);
          last_nxt  = req_id_t'(grant_s);
          beat_nxt  = '0;
          wait_nxt  = '0;
          req_nxt   = 1'b1;
          if (grant_s == REQ_D) begin
            state_nxt = ST_BUSY_D;
            we_nxt    = d_we;
            addr_nxt  = word_align(d_addr);
            wdata_nxt = d_wdata;
          end else begin
            state_nxt = ST_BUSY_I;
            we_nxt    = 1'b0;
            addr_nxt  = word_align(i_addr);
            wdata_nxt = 32'd0;
          end
        end else begin
          req_nxt = 1'b0;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_ack) begin
          wait_nxt = '0;
          if (mem_we) begin
            finish_s = 1'b1;
          end else begin
            rsp_nxt     = mem_rdata;
            i_valid_nxt = (owner_r == REQ_I);
            d_valid_nxt = (owner_r == REQ_D);
            beat_nxt    = beat_r + {{(CNT_W-1){1'b0}}, 1'b1};
            addr_nxt    = mem_addr + 32'd4;
            finish_s    = (beat_r == LAST_BEAT);
          end
        end else begin
          wait_nxt = wait_r + {{(CNT_W-1){1'b0}}, 1'b1};
          // Abort once the wait count reaches TIMEOUT without an ack.
          if (wait_nxt == TMO_CNT) begin
            finish_s = 1'b1;
            err_nxt  = 1'b1;
          end else begin
            finish_s = 1'b0;
          end
        end
        if (finish_s) begin
          req_nxt    = 1'b0;
          state_nxt  = ST_DONE;
          i_done_nxt = (owner_r == REQ_I);
          d_done_nxt = (owner_r == REQ_D);
        end else begin
          req_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        req_nxt   = 1'b0;
      end
      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset clears all and lets d win the next tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      owner_r   <= REQ_I;
      last_r    <= REQ_I;
      beat_r    <= '0;
      wait_r    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      rsp_data  <= 32'd0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      owner_r   <= owner_nxt;
      last_r    <= last_nxt;
      beat_r    <= beat_nxt;
      wait_r    <= wait_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      rsp_data  <= rsp_nxt;
      i_valid   <= i_valid_nxt;
      d_valid   <= d_valid_nxt;
      i_done    <= i_done_nxt;
      d_done    <= d_done_nxt;
      bus_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. The bench plays the
// main memory with random ack delays and random read data, and predicts each
// transaction from a transaction-level model (arbitration by last winner,
// beat address = aligned base + 4*k modulo 2^32, one valid per read beat,
// done in the cycle after the final ack, timeout after TIMEOUT idle cycles).
module tb_mem_arbiter;

  localparam int BURST = 4;
  localparam int TMO   = 255;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] rsp_data;
  logic        i_valid;
  logic        d_valid;
  logic        i_done;
  logic        d_done;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_rsp;
  bit          last_d;

  always #5 clock = ~clock;

  mem_arbiter #(.BURST_LEN(BURST), .TIMEOUT(TMO)) dut (
    .clock     (clock),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .rsp_data  (rsp_data),
    .i_valid   (i_valid),
    .d_valid   (d_valid),
    .i_done    (i_done),
    .d_done    (d_done),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Serve one transaction from its grant edge to the idle cycle after done.
  // Called while the DUT is idle with the owner's request already raised.
  task automatic serve(input bit own_d, input logic [31:0] base, input bit we,
                       input logic [31:0] wdata, input int dmin, input int dmax,
                       input bit no_ack);
    logic [31:0] a;
    logic [31:0] rd;
    int          beats;
    int          dly;
    beats = we ? 1 : BURST;
    a     = base & 32'hFFFF_FFFC;
    rd    = 32'd0;
    tick();
    last_d = own_d;
    // Owner's inputs change after the grant; the latched request must not.
    if (own_d) begin
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_we    = ~d_we;
    end else begin
      i_addr = $urandom;
    end
    if (no_ack) begin
      for (int c = 0; c < TMO; c++) begin
        chk("tmo_req", {31'd0, mem_req}, 32'd1);
        chk("tmo_quiet", {27'd0, i_valid, d_valid, i_done, d_done, bus_err}, 32'd0);
        tick();
      end
      chk("tmo_req_drop", {31'd0, mem_req}, 32'd0);
      chk("tmo_done_i", {31'd0, i_done}, {31'd0, !own_d});
      chk("tmo_done_d", {31'd0, d_done}, {31'd0, own_d});
      chk("tmo_bus_err", {31'd0, bus_err}, 32'd1);
      chk("tmo_rsp", rsp_data, exp_rsp);
    end else begin
      for (int k = 0; k < beats; k++) begin
        dly = $urandom_range(dmax, dmin);
        for (int c = 0; c <= dly; c++) begin
          chk("beat_req", {31'd0, mem_req}, 32'd1);
          chk("beat_addr", mem_addr, a);
          chk("beat_we", {31'd0, mem_we}, {31'd0, we});
          if (we) chk("beat_wdata", mem_wdata, wdata);
          if (c > 0 || k == 0)
            chk("beat_quiet", {27'd0, i_valid, d_valid, i_done, d_done, bus_err}, 32'd0);
          if (c == dly) begin
            rd        = $urandom;
            mem_ack   = 1'b1;
            mem_rdata = rd;
          end
          tick();
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
        if (!we) begin
          exp_rsp = rd;
          chk("rsp_data", rsp_data, rd);
          chk("valid_i", {31'd0, i_valid}, {31'd0, !own_d});
          chk("valid_d", {31'd0, d_valid}, {31'd0, own_d});
        end else begin
          chk("wr_no_valid", {30'd0, i_valid, d_valid}, 32'd0);
        end
        a = a + 32'd4;
        if (k == beats - 1) begin
          chk("last_req_drop", {31'd0, mem_req}, 32'd0);
          chk("done_i", {31'd0, i_done}, {31'd0, !own_d});
          chk("done_d", {31'd0, d_done}, {31'd0, own_d});
          chk("done_err", {31'd0, bus_err}, 32'd0);
        end else begin
          chk("mid_no_done", {30'd0, i_done, d_done}, 32'd0);
        end
      end
    end
    if (own_d) d_req = 1'b0;
    else i_req = 1'b0;
    tick();
    chk("idle_quiet", {26'd0, mem_req, i_valid, d_valid, i_done, d_done, bus_err}, 32'd0);
  endtask

  int          pick;
  bit          first_d;
  bit          rwe;
  logic [31:0] ia, da, wd;

  initial begin
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    exp_rsp = 32'd0; last_d = 1'b0;
    repeat (3) tick();
    chk("rst_ctrl", {25'd0, mem_req, mem_we, i_valid, d_valid, i_done, d_done, bus_err}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rsp", rsp_data, 32'd0);

    // Tie on the first active edge: d write first (ack after 3 cycles), then i read.
    reset = 1'b1;
    i_addr = 32'h0000_0100; i_req = 1'b1;
    d_addr = 32'h0000_2000; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    serve(1'b1, 32'h0000_2000, 1'b1, 32'hDEAD_BEEF, 3, 3, 1'b0);
    serve(1'b0, 32'h0000_0100, 1'b0, 32'd0, 0, 0, 1'b0);

    // Next tie again goes to d; i read wraps past the top of the address space.
    i_addr = 32'hFFFF_FFF8; i_req = 1'b1;
    d_addr = 32'h0000_0044; d_we = 1'b0; d_req = 1'b1;
    serve(1'b1, 32'h0000_0044, 1'b0, 32'd0, 0, 2, 1'b0);
    serve(1'b0, 32'hFFFF_FFF8, 1'b0, 32'd0, 1, 1, 1'b0);

    // mem_ack while idle must change nothing.
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_rsp", rsp_data, exp_rsp);
    chk("idle_ack_quiet", {26'd0, mem_req, i_valid, d_valid, i_done, d_done, bus_err}, 32'd0);

    // Timeout on a d read with no ack.
    d_addr = 32'h0000_0500; d_we = 1'b0; d_req = 1'b1;
    serve(1'b1, 32'h0000_0500, 1'b0, 32'd0, 0, 0, 1'b1);

    // Reset after the 2nd beat of an i read aborts silently.
    i_addr = 32'h0000_3000; i_req = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
    tick();
    mem_rdata = 32'hAAAA_0002;
    tick();
    mem_ack = 1'b0;
    chk("pre_rst_valid", {31'd0, i_valid}, 32'd1);
    chk("pre_rst_addr", mem_addr, 32'h0000_3008);
    reset = 1'b0; i_req = 1'b0;
    tick();
    chk("mid_rst_ctrl", {25'd0, mem_req, mem_we, i_valid, d_valid, i_done, d_done, bus_err}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_rsp", rsp_data, 32'd0);
    exp_rsp = 32'd0; last_d = 1'b0;
    reset = 1'b1;
    tick();
    chk("post_rst_quiet", {26'd0, mem_req, i_valid, d_valid, i_done, d_done, bus_err}, 32'd0);
    i_req = 1'b1;
    serve(1'b0, 32'h0000_3000, 1'b0, 32'd0, 0, 1, 1'b0);

    // Random traffic against the arbitration and beat model.
    for (int n = 0; n < 24; n++) begin
      pick = $urandom_range(2, 0);
      ia   = $urandom;
      da   = $urandom;
      wd   = $urandom;
      rwe  = 1'($urandom_range(1, 0));
      i_addr = ia; d_addr = da; d_wdata = wd; d_we = rwe;
      i_req = (pick != 1);
      d_req = (pick != 0);
      first_d = (pick == 2) ? !last_d : (pick == 1);
      if (first_d) serve(1'b1, da, rwe, wd, 0, 3, 1'b0);
      else serve(1'b0, ia, 1'b0, 32'd0, 0, 3, 1'b0);
      if (pick == 2) begin
        if (first_d) serve(1'b0, ia, 1'b0, 32'd0, 0, 3, 1'b0);
        else serve(1'b1, da, rwe, wd, 0, 3, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
